// File: rtl/divide_arbiter.sv
// Round-robin front end sharing one pipelined fixed-point divider among N requesters.
// A tag pipeline matched to the divider latency steers each result back as a one-cycle strobe.
module divide_arbiter #(
    parameter int unsigned N           = 3,
    parameter int unsigned DIV_LATENCY = 26
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [N-1:0]    req_valid_in,
    input  logic [N*24-1:0] req_dividend_in,
    input  logic [N*24-1:0] req_divisor_in,
    output logic [N-1:0]    req_ready_out,
    output logic [23:0]     div_dividend_out,
    output logic [23:0]     div_divisor_out,
    input  logic [25:0]     div_quotient_in,
    input  logic            div_overflow_in,
    output logic [N-1:0]    res_valid_out,
    output logic [25:0]     res_quotient_out,
    output logic            res_overflow_out,
    output logic            busy_out
);
    localparam int unsigned IDW  = $clog2(N);
    localparam int unsigned TAIL = DIV_LATENCY;

    logic [IDW-1:0]   r_ptr;
    logic [TAIL:0]    r_tag_valid;
    logic [TAIL:0]    r_tag_zdiv;
    logic [IDW-1:0]   r_tag_id [TAIL+1];

    logic [N-1:0]     w_grant;
    logic             w_xfer;
    logic [IDW-1:0]   w_gnt_id;
    logic [23:0]      w_dividend;
    logic [23:0]      w_divisor;
    logic             w_zdiv;
    logic [N-1:0]     w_res_valid;

    // First valid requester at or after the pointer wins; nothing is granted during reset.
    always_comb begin
        w_grant  = '0;
        w_xfer   = 1'b0;
        w_gnt_id = '0;
        for (int k = 0; k < int'(N); k++) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(r_ptr) + k) % int'(N));
            if (rst_n_in && !w_xfer && req_valid_in[idx]) begin
                w_xfer        = 1'b1;
                w_gnt_id      = idx;
                w_grant[idx]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_dividend = '0;
        w_divisor  = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (w_grant[k]) begin
                w_dividend = req_dividend_in[24*k +: 24];
                w_divisor  = req_divisor_in[24*k +: 24];
            end
        end
    end

    assign w_zdiv        = (w_divisor == 24'd0);
    assign req_ready_out = w_grant;

    always_comb begin
        w_res_valid = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_res_valid[k] = r_tag_valid[TAIL] && (r_tag_id[TAIL] == IDW'(k));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ptr            <= '0;
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
        end else if (w_xfer) begin
            r_ptr            <= (w_gnt_id == IDW'(N - 1)) ? '0 : w_gnt_id + 1'b1;
            // Zero divisors are resolved at the tail, so feed the divider something harmless.
            div_dividend_out <= w_zdiv ? 24'd0 : w_dividend;
            div_divisor_out  <= w_zdiv ? 24'd0 : w_divisor;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tag_valid <= '0;
            r_tag_zdiv  <= '0;
            for (int k = 0; k <= int'(TAIL); k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_valid <= {r_tag_valid[TAIL-1:0], w_xfer};
            r_tag_zdiv  <= {r_tag_zdiv[TAIL-1:0], w_xfer && w_zdiv};
            r_tag_id[0] <= w_gnt_id;
            for (int k = 1; k <= int'(TAIL); k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_valid_out    <= '0;
            res_quotient_out <= '0;
            res_overflow_out <= 1'b0;
        end else begin
            res_valid_out <= w_res_valid;
            if (r_tag_valid[TAIL]) begin
                res_quotient_out <= r_tag_zdiv[TAIL] ? 26'h3FFFFFF : div_quotient_in;
                res_overflow_out <= r_tag_zdiv[TAIL] ? 1'b1 : div_overflow_in;
            end
        end
    end

    assign busy_out = |r_tag_valid;

endmodule

// File: tb/tb_divide_arbiter.sv
// Directed and random stimulus for divide_arbiter against a transaction-level model
// (round-robin choice, expected-result queue) plus a behavioural pipelined divider.
module tb_divide_arbiter;
    localparam int N  = 3;
    localparam int DL = 26;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*24-1:0] req_dividend;
    logic [N*24-1:0] req_divisor;
    logic [N-1:0]    req_ready;
    logic [23:0]     div_a;
    logic [23:0]     div_b;
    logic [25:0]     div_q;
    logic            div_ovf;
    logic [N-1:0]    res_valid;
    logic [25:0]     res_q;
    logic            res_ovf;
    logic            busy;

    always #5 clk = ~clk;

    divide_arbiter #(.N(N), .DIV_LATENCY(DL)) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .req_valid_in     (req_valid),
        .req_dividend_in  (req_dividend),
        .req_divisor_in   (req_divisor),
        .req_ready_out    (req_ready),
        .div_dividend_out (div_a),
        .div_divisor_out  (div_b),
        .div_quotient_in  (div_q),
        .div_overflow_in  (div_ovf),
        .res_valid_out    (res_valid),
        .res_quotient_out (res_q),
        .res_overflow_out (res_ovf),
        .busy_out         (busy)
    );

    // Unsigned Q1.25 divide: {overflow, quotient}, saturating when the quotient needs > 26 bits.
    function automatic logic [26:0] fx_divide(input logic [23:0] a, input logic [23:0] b);
        logic [48:0] full;
        if (b == 24'd0) return 27'd0;
        full = {a, 25'd0} / {25'd0, b};
        if (full >= 49'h4000000) return {1'b1, 26'h3FFFFFF};
        return {1'b0, full[25:0]};
    endfunction

    function automatic logic [26:0] expected_result(input logic [23:0] a, input logic [23:0] b);
        if (b == 24'd0) return {1'b1, 26'h3FFFFFF};
        return fx_divide(a, b);
    endfunction

    logic [26:0] dpipe [DL];
    always @(posedge clk) begin
        dpipe[0] <= fx_divide(div_a, div_b);
        for (int k = 1; k < DL; k++) dpipe[k] <= dpipe[k-1];
    end
    assign div_q   = dpipe[DL-1][25:0];
    assign div_ovf = dpipe[DL-1][26];

    typedef struct {
        int          id;
        logic [26:0] r;
        int          due;
        int          gc;
    } item_t;

    item_t       exp_q[$];
    int          ptr;
    int          cyc;
    int          last_g;
    logic [23:0] exp_da;
    logic [23:0] exp_db;
    logic [25:0] exp_rq;
    logic        exp_ro;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [23:0] a, input logic [23:0] b);
        req_valid[i]           = v;
        req_dividend[24*i +: 24] = a;
        req_divisor[24*i +: 24]  = b;
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        int          g;
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        logic         ebusy;
        item_t        it;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            ptr    = 0;
            exp_da = '0;
            exp_db = '0;
            exp_rq = '0;
            exp_ro = 1'b0;
        end
        eg = '0;
        g  = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (g < 0 && req_valid[idx]) begin
                    g       = idx;
                    eg[idx] = 1'b1;
                end
            end
        end
        chk("grant", 32'(req_ready), 32'(eg));
        erv = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            it          = exp_q.pop_front();
            erv[it.id]  = 1'b1;
            exp_rq      = it.r[25:0];
            exp_ro      = it.r[26];
        end
        chk("res_valid", 32'(res_valid), 32'(erv));
        chk("res_quotient", 32'(res_q), 32'(exp_rq));
        chk("res_overflow", 32'(res_ovf), 32'(exp_ro));
        chk("div_dividend", 32'(div_a), 32'(exp_da));
        chk("div_divisor", 32'(div_b), 32'(exp_db));
        ebusy = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].gc < cyc) ebusy = 1'b1;
        chk("busy", 32'(busy), 32'(ebusy));
        last_g = g;
        if (g >= 0) begin
            logic [23:0] a;
            logic [23:0] b;
            a  = req_dividend[24*g +: 24];
            b  = req_divisor[24*g +: 24];
            it = '{id: g, r: expected_result(a, b), due: cyc + DL + 2, gc: cyc};
            exp_q.push_back(it);
            exp_da = (b == 24'd0) ? 24'd0 : a;
            exp_db = (b == 24'd0) ? 24'd0 : b;
            ptr    = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic renew_granted();
        if (last_g >= 0)
            set_req(last_g, 1'b1, 24'($urandom), 24'($urandom_range(1, 24'hFFFFFF)));
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        cyc          = 0;
        ptr          = 0;
        last_g       = -1;
        exp_q.delete();
        rst_n        = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single request from requester 0.
        set_req(0, 1'b1, 24'h846A97, 24'hC9FAA4);
        tick();
        idle(30);

        // Overflowing quotient from requester 2.
        set_req(2, 1'b1, 24'hF46A97, 24'h39FAA4);
        tick();
        idle(30);

        // All three valid for nine cycles: grants must rotate with no gaps.
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 24'($urandom), 24'($urandom_range(1, 24'hFFFFFF)));
        repeat (9) begin
            tick();
            renew_granted();
        end
        idle(32);

        // Zero divisor sandwiched between two normal requests.
        set_req(0, 1'b1, 24'h123456, 24'h345678);
        tick();
        req_valid = '0;
        set_req(1, 1'b1, 24'hABCDEF, 24'h000000);
        tick();
        req_valid = '0;
        set_req(2, 1'b1, 24'h400000, 24'h800000);
        tick();
        idle(32);

        // Reset with five results in flight; none may ever surface.
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 24'($urandom), 24'($urandom_range(1, 24'hFFFFFF)));
        repeat (5) begin
            tick();
            renew_granted();
        end
        idle(5);
        for (int i = 0; i < N; i++) req_valid[i] = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        req_valid = '0;
        rst_n     = 1'b1;
        idle(30);
        set_req(2, 1'b1, 24'h0F0F0F, 24'h00F0F0);
        tick();
        idle(30);

        // Requester 1 withdraws after losing to 0; pointer must still sit at 1.
        set_req(0, 1'b1, 24'h111111, 24'h222222);
        set_req(1, 1'b1, 24'h333333, 24'h444444);
        tick();
        req_valid = '0;
        tick();
        set_req(0, 1'b1, 24'h555555, 24'h666666);
        set_req(2, 1'b1, 24'h777777, 24'h888888);
        tick();
        idle(30);

        // Random traffic: hold until granted, occasional withdrawal and zero divisors.
        repeat (400) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (i == last_g || !req_valid[i]) begin
                    logic [23:0] b;
                    b = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 24'hFFFFFF));
                    set_req(i, 1'($urandom_range(0, 1)), 24'($urandom), b);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        idle(32);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/divide_arbiter.md
# divide_arbiter

Round-robin arbiter that shares one fully pipelined 24-bit fixed-point divider (dividend/divisor in, 26-bit quotient plus overflow flag out, one new operand pair accepted per cycle, no valid port) among N requesters, such as the per-vertex perspective-divide units of the rasterizer front end. It grants at most one request per cycle and registers the operands into the divider. A tag pipeline matched to the divider latency routes each result back to its requester as a one-cycle pulse. Divide-by-zero is resolved locally without changing result order.

## Interface
- N, default 3: number of requesters, 2..8.
- DIV_LATENCY, default 26: cycles from operands on div_dividend_out/div_divisor_out to the matching result on div_quotient_in/div_overflow_in.
- clk_in  input  1  system clock, all state on rising edge.
- rst_n_in  input  1  reset; one clock; reset is asynchronous and active-low.
- req_valid_in  input  N  per-requester request valid.
- req_dividend_in  input  N×24  packed dividends, requester i at [24i+23:24i].
- req_divisor_in  input  N×24  packed divisors, same packing.
- req_ready_out  output  N  one-hot (or zero) grant, combinational.
- div_dividend_out  output  24  registered dividend to divider.
- div_divisor_out  output  24  registered divisor to divider.
- div_quotient_in  input  26  divider quotient.
- div_overflow_in  input  1  divider overflow.
- res_valid_out  output  N  one-hot result strobe, registered.
- res_quotient_out  output  26  result quotient, shared bus.
- res_overflow_out  output  1  result overflow, shared bus.
- busy_out  output  1  high while any granted request has not returned.

## Operation
- Round-robin pointer ptr (0..N-1, reset 0). Search order ptr, ptr+1, …, wrapping mod N. The first i with req_valid_in[i]=1 gets req_ready_out[i]=1. All others get 0.
- A transfer occurs when req_valid_in[i] && req_ready_out[i]. On a transfer, ptr <= (i+1) mod N. With no transfer, ptr holds.
- Requesters hold valid and operands stable until granted. Dropping valid before grant is legal, and no transfer occurs.
- On a transfer with divisor != 0, the operands are registered to div_dividend_out/div_divisor_out.
- On a transfer with divisor == 0, div_* outputs are driven to 0/0. The tag is marked zero-divide.
- With no transfer, div_* outputs hold their previous value. The divider output is ignored.
- Tag pipeline has DIV_LATENCY+1 stages. Each stage holds {valid, id[clog2(N)-1:0], zdiv}. It is loaded at grant and shifts every cycle.
- At the tag pipeline tail, when valid=1:
  - res_valid_out[id] <= 1.
  - If zdiv=0, quotient/overflow are taken from div_*_in.
  - If zdiv=1, res_quotient_out <= 26'h3FFFFFF and res_overflow_out <= 1.
- At the tail with valid=0, res_valid_out <= 0. res_quotient_out/res_overflow_out hold.
- No result backpressure. A requester must sample in the strobe cycle.
- busy_out = OR of all tag-stage valid bits. It is registered-derived, with no combinational input path.
- Results leave in grant order. Throughput is one result per cycle sustained.

## Timing
- Grant in cycle t. div_* operands are valid in t+1. The divider result is valid in t+1+DIV_LATENCY. res_valid_out is high for exactly cycle t+2+DIV_LATENCY.
- Total request-to-result latency is DIV_LATENCY+2 = 28 cycles at defaults.
- Reset (asynchronous assert, synchronous-safe deassert) sets:
  - ptr=0 and all tag valids=0.
  - res_valid_out=0, res_quotient_out=0, res_overflow_out=0.
  - div_dividend_out=0, div_divisor_out=0, busy_out=0.
- req_ready_out is 0 while rst_n_in=0.
- Reset mid-operation: all in-flight results are discarded, and no res_valid_out pulse ever appears for them. The first grant after release returns normally.
- All N valid continuously: grants rotate 0,1,…,N-1,0,… with no gaps.
- A single requester continuously valid is granted every cycle.
- Simultaneous grant and result-out in the same cycle is normal and independent.

## Test plan
- Single request: requester 0 sends dividend 0x846A97, divisor 0xC9FAA4 at cycle t. Required:
  - res_valid_out=3'b001 at exactly t+28.
  - quotient 0x14FAA14, overflow 0.
- Overflow case: requester 2 sends 0xF46A97 / 0x39FAA4. Required: res_valid_out=3'b100 at t+28, res_overflow_out=1.
- Fairness: all three valid for 9 cycles with distinct operands. Required:
  - Grants are 0,1,2,0,1,2,0,1,2.
  - Results return in the same order on 9 consecutive cycles, each quotient matching a reference model.
- Zero divisor from requester 1, issued between two normal requests. Required:
  - Middle result is quotient 0x3FFFFFF, overflow 1.
  - Order is preserved and neighbouring results are correct.
- Reset mid-flight: issue 5 requests, assert rst_n_in low for 2 cycles at grant+10. Required:
  - No res_valid_out pulses follow, busy_out=0, req_ready_out=0 during reset.
  - A new request after release returns correctly at +28.
- Withdrawn request: requester 1 valid but requester 0 is granted, then requester 1 drops valid. Required: no grant or result for requester 1, and ptr still advances to 1.
